// File: rtl/if_resp_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : if_resp_queue                                                  |
// | Brief   : Fetch response queue between the PC stage and IF/ID; drives    |
// |           the 1-cycle-latency instruction SRAM and queues {pc,inst,adel} |
// |           with credit-based request acceptance.                          |
// | Options : IFQ_BYPASS_EN - empty-queue responses drive out_* at N+1.      |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module if_resp_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_req,
    input  logic [WIDTH-1:0] fetch_pc,
    output logic             req_ready,
    output logic             inst_sram_en,
    output logic [WIDTH-1:0] inst_sram_addr,
    input  logic [WIDTH-1:0] inst_sram_rdata,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_inst,
    output logic             out_adel
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    logic [WIDTH-1:0]   r_pc_mem   [DEPTH];
    logic [WIDTH-1:0]   r_inst_mem [DEPTH];
    logic [DEPTH-1:0]   r_adel_mem;
    logic [c_cnt_w-1:0] r_count;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic               r_pend;
    logic [WIDTH-1:0]   r_pend_pc;
    logic               r_pend_adel;

    logic [c_cnt_w-1:0] w_credit;
    logic               w_issue;
    logic               w_adel;
    logic               w_resp;
    logic [WIDTH-1:0]   w_resp_inst;
    logic               w_q_empty;
    logic               w_q_pop;
    logic               w_push;

    // The pending response holds a slot, so a full queue can never be overrun.
    assign w_credit       = r_count + {{c_ptr_w{1'b0}}, r_pend};
    assign req_ready      = !flush && (w_credit < c_depth);
    assign w_issue        = fetch_req && req_ready;
    assign w_adel         = (fetch_pc[1:0] != 2'b00);
    assign inst_sram_en   = w_issue && !w_adel;
    assign inst_sram_addr = fetch_pc;

    assign w_resp      = r_pend && !flush;
    assign w_resp_inst = r_pend_adel ? '0 : inst_sram_rdata;
    assign w_q_empty   = (r_count == '0);
    assign w_q_pop     = !flush && out_ready && !w_q_empty;

`ifdef IFQ_BYPASS_EN
    logic w_bypass;

    assign w_bypass = w_q_empty && w_resp;
    // A bypassed response taken by decode this cycle never enters storage.
    assign w_push   = w_resp && !(w_bypass && out_ready);

    always_comb begin
        out_valid = 1'b0;
        out_pc    = '0;
        out_inst  = '0;
        out_adel  = 1'b0;
        if (!w_q_empty) begin
            out_valid = 1'b1;
            out_pc    = r_pc_mem[r_rd_ptr];
            out_inst  = r_inst_mem[r_rd_ptr];
            out_adel  = r_adel_mem[r_rd_ptr];
        end else if (w_bypass) begin
            out_valid = 1'b1;
            out_pc    = r_pend_pc;
            out_inst  = w_resp_inst;
            out_adel  = r_pend_adel;
        end
    end
`else
    assign w_push = w_resp;

    always_comb begin
        out_valid = 1'b0;
        out_pc    = '0;
        out_inst  = '0;
        out_adel  = 1'b0;
        if (!w_q_empty) begin
            out_valid = 1'b1;
            out_pc    = r_pc_mem[r_rd_ptr];
            out_inst  = r_inst_mem[r_rd_ptr];
            out_adel  = r_adel_mem[r_rd_ptr];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_pend      <= 1'b0;
            r_pend_pc   <= '0;
            r_pend_adel <= 1'b0;
        end else if (flush) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_pend   <= 1'b0;
        end else begin
            r_pend <= w_issue;
            if (w_issue) begin
                r_pend_pc   <= fetch_pc;
                r_pend_adel <= w_adel;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_q_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_q_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; out_* are qualified by the entry count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]   <= r_pend_pc;
            r_inst_mem[r_wr_ptr] <= w_resp_inst;
            r_adel_mem[r_wr_ptr] <= r_pend_adel;
        end
    end

endmodule
`default_nettype wire
